// File: rtl/vga_pkg.sv
// Shared types and constants for the video memory fetcher.
package vga_pkg;

  localparam int VGA_ADR_W     = 30;
  localparam int VGA_BURST_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_EOV,
    ST_CHECK,
    ST_BURST,
    ST_DRAIN
  } vga_fetch_state_t;

endpackage

// File: rtl/vga_fetch_ctr.sv
// Word/line down-counter pair for the frame fetcher; flags the last word of a
// line (eol) and of a frame (eof) for the beat currently on the bus.
module vga_fetch_ctr (
  input  logic        clk,
  input  logic        nrst,
  input  logic        load,
  input  logic        dec,
  input  logic [15:0] hwords,
  input  logic [15:0] vlines,
  output logic [15:0] word_cnt,
  output logic        eol,
  output logic        eof
);

  logic [15:0] line_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      word_cnt <= 16'd0;
      line_cnt <= 16'd0;
    end else if (load) begin
      word_cnt <= hwords;
      line_cnt <= vlines;
    end else if (dec) begin
      if (eol) begin
        word_cnt <= hwords;
        if (line_cnt != 16'd0)
          line_cnt <= line_cnt - 16'd1;
      end else begin
        word_cnt <= word_cnt - 16'd1;
      end
    end
  end

  assign eol = (word_cnt == 16'd1);
  assign eof = eol && (line_cnt <= 16'd1);

endmodule

// File: rtl/vga_fetch.sv
// Frame-buffer burst fetcher feeding the pixel line FIFO, frame-aligned to eov.
// Optional VGA_FETCH_STRIDE_EN adds a vstride input for non-contiguous lines.
module vga_fetch
  import vga_pkg::*;
#(
  parameter int BURST_LEN = VGA_BURST_LEN
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ctrl_ven,
  input  logic [31:2] vbase,
  input  logic [15:0] hwords,
  input  logic [15:0] vlines,
  input  logic        eov,
  input  logic [7:0]  fifo_free,
`ifdef VGA_FETCH_STRIDE_EN
  input  logic [15:0] vstride,
`endif
  output logic        mem_req,
  output logic [31:2] mem_adr,
  output logic        mem_last,
  input  logic        mem_ack,
  input  logic [31:0] mem_dat,
  output logic        fifo_wr,
  output logic [31:0] fifo_dat,
  output logic        fifo_clr,
  output logic        frame_done,
  output logic        sync_err
);

  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  vga_fetch_state_t     state;
  logic [31:2]          line_start;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [BEAT_W-1:0]    n;
  logic                 drain_idle;
  logic [15:0]          word_cnt;
  logic                 eol;
  logic                 eof;
  logic [15:0]          line_step;
  logic [VGA_ADR_W-1:0] next_line;
  logic                 cfg_ok;
  logic                 beat_ack;
  logic                 last_beat;
  logic                 reload;
  logic                 ctr_dec;
  logic                 frame_end;

`ifdef VGA_FETCH_STRIDE_EN
  assign line_step = vstride;
`else
  assign line_step = hwords;
`endif

  assign next_line = line_start + VGA_ADR_W'(line_step);
  assign cfg_ok    = (hwords != 16'd0) && (vlines != 16'd0);
  assign beat_ack  = mem_req && mem_ack;
  assign last_beat = beat_ack && (beat_cnt == BEAT_W'(1));
  assign ctr_dec   = (state == ST_BURST) && beat_ack;
  assign frame_end = ctr_dec && eof;

  // Burst length: never past the line end, never above BURST_LEN.
  always_comb begin
    if (word_cnt < 16'(BURST_LEN))
      n = word_cnt[BEAT_W-1:0];
    else
      n = BEAT_W'(BURST_LEN);
  end

  // A frame (re)load restarts address and counters from vbase.
  always_comb begin
    reload = 1'b0;
    case (state)
      ST_WAIT_EOV, ST_CHECK: reload = ctrl_ven && eov && cfg_ok;
      ST_BURST:              reload = ctrl_ven && eov && last_beat && cfg_ok;
      ST_DRAIN:              reload = ctrl_ven && !drain_idle && last_beat && cfg_ok;
      default:               reload = 1'b0;
    endcase
  end

  vga_fetch_ctr u_ctr (
    .clk      (clk),
    .nrst     (nrst),
    .load     (reload),
    .dec      (ctr_dec),
    .hwords   (hwords),
    .vlines   (vlines),
    .word_cnt (word_cnt),
    .eol      (eol),
    .eof      (eof)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_adr    <= '0;
      mem_last   <= 1'b0;
      fifo_wr    <= 1'b0;
      fifo_dat   <= '0;
      fifo_clr   <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      line_start <= '0;
      beat_cnt   <= '0;
      drain_idle <= 1'b0;
    end else begin
      fifo_wr    <= 1'b0;
      fifo_clr   <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          sync_err <= 1'b0;
          if (ctrl_ven)
            state <= ST_WAIT_EOV;
        end

        ST_WAIT_EOV: begin
          if (!ctrl_ven)
            state <= ST_IDLE;
          else if (reload)
            state <= ST_CHECK;
        end

        ST_CHECK: begin
          if (!ctrl_ven) begin
            state <= ST_IDLE;
          end else if (eov) begin
            sync_err <= 1'b1;
            if (!reload)
              state <= ST_WAIT_EOV;
          end else if (8'(n) <= fifo_free) begin
            state    <= ST_BURST;
            mem_req  <= 1'b1;
            beat_cnt <= n;
            mem_last <= (n == BEAT_W'(1));
          end
        end

        ST_BURST: begin
          if (beat_ack) begin
            beat_cnt <= beat_cnt - BEAT_W'(1);
            mem_last <= (beat_cnt == BEAT_W'(2));
            mem_adr  <= eol ? next_line : mem_adr + 30'd1;
            if (eol)
              line_start <= next_line;
            // A beat coinciding with an early eov belongs to the aborted frame.
            if (!(eov && !frame_end)) begin
              fifo_wr  <= 1'b1;
              fifo_dat <= mem_dat;
            end
            frame_done <= frame_end;
          end
          if (last_beat) begin
            mem_req  <= 1'b0;
            mem_last <= 1'b0;
            if (eov && !frame_end)
              sync_err <= 1'b1;
            if (!ctrl_ven)
              state <= ST_IDLE;
            else if (reload)
              state <= ST_CHECK;
            else if (frame_end || eov)
              state <= ST_WAIT_EOV;
            else
              state <= ST_CHECK;
          end else if (!ctrl_ven) begin
            state      <= ST_DRAIN;
            drain_idle <= 1'b1;
          end else if (eov) begin
            sync_err   <= 1'b1;
            state      <= ST_DRAIN;
            drain_idle <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (!ctrl_ven)
            drain_idle <= 1'b1;
          if (beat_ack) begin
            beat_cnt <= beat_cnt - BEAT_W'(1);
            mem_last <= (beat_cnt == BEAT_W'(2));
            mem_adr  <= mem_adr + 30'd1;
          end
          if (last_beat) begin
            mem_req  <= 1'b0;
            mem_last <= 1'b0;
            if (reload)
              state <= ST_CHECK;
            else if (ctrl_ven && !drain_idle)
              state <= ST_WAIT_EOV;
            else
              state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      if (reload) begin
        mem_adr    <= vbase;
        line_start <= vbase;
        fifo_clr   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/vga_fetch.md
# vga_fetch

Master-clock-domain video memory fetcher. It produces frame-buffer read bursts that fill the pixel line FIFO ahead of the pixel generator. Frame start is aligned to the pixel generator's end-of-vertical pulse (`eov`, already synchronized to mclk). The block sits between the bus master (memory side) and the line FIFO (pixel side).

## Interface
- `BURST_LEN`, 8: maximum words per memory burst, power of two, 2..64.
- `clk` in 1: master clock, the same clock that drives `eov`.
- `nrst` in 1: asynchronous, active-low reset.
- `ctrl_ven` in 1: video enable.
- `vbase` in [31:2]: frame-buffer base word address.
- `hwords` in [15:0]: words per line.
- `vlines` in [15:0]: lines per frame.
- `eov` in 1: one-cycle end-of-frame pulse from the pixel generator.
- `fifo_free` in [7:0]: free entries in the line FIFO.
- `mem_req` out 1: burst request, held high for the whole burst.
- `mem_adr` out [31:2]: current word address.
- `mem_last` out 1: marks the final beat of the burst.
- `mem_ack` in 1: beat accepted; `mem_dat` is valid in the same cycle.
- `mem_dat` in [31:0]: read data.
- `fifo_wr` out 1: line FIFO write strobe.
- `fifo_dat` out [31:0]: line FIFO write data.
- `fifo_clr` out 1: one-cycle FIFO flush pulse.
- `frame_done` out 1: one-cycle pulse after the last word of a frame is accepted.
- `sync_err` out 1: sticky flag; `eov` arrived before the frame was fully fetched.

## Operation
- States:
  - IDLE: nothing fetched.
  - WAIT_EOV: waiting for frame start.
  - CHECK: decide whether a burst can start.
  - BURST: beats in flight.
  - DRAIN: finishing a burst before a restart or stop.
- IDLE → WAIT_EOV when `ctrl_ven`=1.
- WAIT_EOV on `eov`:
  - Load line-start address and `mem_adr` with `vbase`.
  - Load word counter with `hwords`, line counter with `vlines`.
  - Pulse `fifo_clr`, then go to CHECK.
- CHECK:
  - Compute n = min(`BURST_LEN`, words left in line).
  - If `fifo_free` ≥ n, go to BURST with beat counter = n; otherwise stay in CHECK.
  - Bursts never cross a line end.
- BURST:
  - On each `mem_req`&`mem_ack`: `mem_adr`+1, word and beat counters −1.
  - Last beat with words left in line: go to CHECK.
  - End of line: line counter −1 and `mem_adr` ← line start + `hwords`.
  - End of frame: pulse `frame_done`, go to WAIT_EOV.
- Address arithmetic is 30-bit and wraps modulo 2^30. The line counter saturates at 0.
- `hwords`=0 or `vlines`=0: WAIT_EOV never leaves, no requests are issued, `eov` is ignored.
- `eov` in CHECK: set `sync_err`, reload frame as in WAIT_EOV, pulse `fifo_clr`.
- `eov` in BURST: set `sync_err` and enter DRAIN. Remaining beats complete with data discarded (`fifo_wr` suppressed). Then reload the frame, pulse `fifo_clr`, go to CHECK.
- `ctrl_ven`=0:
  - From WAIT_EOV or CHECK: go to IDLE next cycle.
  - From BURST: go to DRAIN, complete the beats, then IDLE.
  - In IDLE, `sync_err` clears.
- `eov` and last frame beat in the same cycle: counts as the normal end, no error. `frame_done` pulses and the reload happens immediately, skipping WAIT_EOV.

## Timing
- Reset values:
  - `mem_req`, `mem_last`, `fifo_wr`, `fifo_clr`, `frame_done`, `sync_err`: 0.
  - `mem_adr`, `fifo_dat`: 0.
  - State: IDLE.
- All outputs are registered.
- `mem_req` rises 1 cycle after CHECK accepts, and falls the cycle after the ack of the beat carrying `mem_last`.
- `mem_adr` is stable while `mem_req`&!`mem_ack`.
- `mem_last` is high whenever the beat counter is 1 and `mem_req` is high.
- `fifo_wr`/`fifo_dat`: 1-cycle latency from `mem_ack`/`mem_dat`.
- Burst-to-burst gap is at least 1 cycle (CHECK).
- `frame_done` is asserted in the cycle after the final ack.
- `fifo_clr` is asserted in the cycle after `eov` is taken.

## Configuration
- `VGA_FETCH_STRIDE_EN` defined:
  - Adds input `vstride` [15:0] (words).
  - At end of line, line start ← line start + `vstride`; `hwords` words are fetched per line.
- Undefined: there is no `vstride` port and lines are contiguous (stride = `hwords`).

## Structure
- Shared package `vga_pkg`:
  - `vga_fetch_state_t` enum.
  - Word-address width constant (30).
  - `BURST_LEN` default.
- Sub-module `vga_fetch_ctr`:
  - Word/line down-counter pair with load and decrement.
  - Outputs end-of-line and end-of-frame flags.
- FSM, address path and data register stay in the top level.

## Test plan
- Frame fetch, always-ack: `vbase`=0x100, `hwords`=20, `vlines`=2, `BURST_LEN`=8, `fifo_free`=255, then `eov`.
  - Bursts of 8,8,4 per line.
  - Addresses 0x100..0x127, with `mem_last` on 0x107, 0x10F, 0x113, ….
  - 40 `fifo_wr`, one `frame_done`.
- FIFO backpressure: `fifo_free`=5 with a 8-word burst pending → no `mem_req`. Raise to 8 → `mem_req` the next cycle.
- Early `eov` mid-burst, after ack 3 of 8:
  - Beats 4..8 complete with no `fifo_wr`.
  - `sync_err`=1, `fifo_clr` pulses, next burst starts at `vbase`.
- Wait states: `mem_ack` every 3rd cycle → `mem_adr` holds between acks, and `fifo_dat` matches `mem_dat` one cycle later.
- Disable mid-burst: `ctrl_ven`=0 at beat 2 → burst completes, then IDLE, `sync_err` cleared, no further `mem_req`.
- Wrap: `vbase`=0x3FFFFFFE, `hwords`=4 → addresses 0x3FFFFFFE, 0x3FFFFFFF, 0x0, 0x1.
- With `VGA_FETCH_STRIDE_EN`: `hwords`=4, `vstride`=16 → line 2 starts at `vbase`+16.
